// File: rtl/key_pkg.sv
// Shared types and default timing for the button conditioning stage.
// Default timing assumes a 65 MHz system clock.
package key_pkg;

   typedef enum logic [1:0] {
      KEY_IDLE,
      KEY_DEB_PRESS,
      KEY_HELD,
      KEY_DEB_REL
   } key_state_t;

   // 10 ms debounce window and 100 ms auto-repeat period at 65 MHz
   localparam int KEY_CNT_MAX_65M       = 650_000;
   localparam int KEY_REPEAT_PERIOD_65M = 6_500_000;

   function automatic int key_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, debounce counter
// and hold-to-repeat down-counter. All outputs are registered.
//
//  state          | meaning
//  ---------------+-----------------------------------------------------
//  KEY_IDLE       | released and accepted, waiting for sync==1
//  KEY_DEB_PRESS  | sync high, counting stable cycles toward a press
//  KEY_HELD       | pressed and accepted, repeat timer running
//  KEY_DEB_REL    | sync low, counting stable cycles toward a release
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int CNT_MAX       = KEY_CNT_MAX_65M,
   parameter int REPEAT_DELAY  = 0,
   parameter int REPEAT_PERIOD = KEY_REPEAT_PERIOD_65M
) (
   input  logic clk,
   input  logic rst,
   input  logic key_in,
   output logic key_level,
   output logic key_press,
   output logic key_release
);

   localparam int CNT_W = $clog2(CNT_MAX + 1);
   localparam int RPT_W = $clog2(key_max(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CNT_MAX - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY);
   localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD);
   localparam logic [RPT_W-1:0] RPT_ONE    = RPT_W'(1);
   localparam bit               RPT_EN     = (REPEAT_DELAY > 0);

   logic [1:0]       sync_q;
   logic             key_sync;
   key_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RPT_W-1:0] rpt_q, rpt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;

   assign key_sync = sync_q[1];

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q    <= 2'b00;
         state_q   <= KEY_IDLE;
         cnt_q     <= '0;
         rpt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], key_in};
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rpt_q     <= rpt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         KEY_IDLE:      if (key_sync) state_d = KEY_DEB_PRESS;
         KEY_DEB_PRESS: begin
            if (!key_sync)              state_d = KEY_IDLE;
            else if (cnt_q == CNT_LAST) state_d = KEY_HELD;
         end
         KEY_HELD:      if (!key_sync) state_d = KEY_DEB_REL;
         KEY_DEB_REL: begin
            if (key_sync)               state_d = KEY_HELD;
            else if (cnt_q == CNT_LAST) state_d = KEY_IDLE;
         end
         default:       state_d = KEY_IDLE;
      endcase
   end

   always_comb begin
      cnt_d     = cnt_q;
      rpt_d     = rpt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      case (state_q)
         KEY_IDLE: begin
            level_d = 1'b0;
            cnt_d   = key_sync ? CNT_ONE : '0;
         end
         KEY_DEB_PRESS: begin
            if (!key_sync) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               level_d = 1'b1;
               press_d = 1'b1;
               rpt_d   = RPT_DELAY;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         KEY_HELD: begin
            if (!key_sync) begin
               cnt_d = CNT_ONE;
            end else if (RPT_EN) begin
               // reload on terminal count so the timer can never wrap
               if (rpt_q <= RPT_ONE) begin
                  press_d = 1'b1;
                  rpt_d   = RPT_PERIOD;
               end else begin
                  rpt_d = rpt_q - RPT_ONE;
               end
            end
         end
         KEY_DEB_REL: begin
            if (key_sync) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d     = '0;
               level_d   = 1'b0;
               release_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   assign key_level   = level_q;
   assign key_press   = press_q;
   assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// Four-button (by default) input conditioning: independent synchronise,
// debounce and auto-repeat channels, outputs concatenated by key index.
module key_debounce
   import key_pkg::*;
#(
   parameter int N_KEYS        = 4,
   parameter int CNT_MAX       = KEY_CNT_MAX_65M,
   parameter int REPEAT_DELAY  = 0,
   parameter int REPEAT_PERIOD = KEY_REPEAT_PERIOD_65M
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_KEYS-1:0] key_in,
   output logic [N_KEYS-1:0] key_level,
   output logic [N_KEYS-1:0] key_press,
   output logic [N_KEYS-1:0] key_release
);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
      key_debounce_ch #(
         .CNT_MAX      (CNT_MAX),
         .REPEAT_DELAY (REPEAT_DELAY),
         .REPEAT_PERIOD(REPEAT_PERIOD)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .key_in     (key_in[g]),
         .key_level  (key_level[g]),
         .key_press  (key_press[g]),
         .key_release(key_release[g])
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: two DUTs (auto-repeat on / off) driven from the same
// buttons, compared every cycle against a run-length reference model.
module tb_key_debounce;

   localparam int NK = 4;
   localparam int CM = 8;
   localparam int RD = 20;
   localparam int RP = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [NK-1:0] key_in = '1;
   logic [NK-1:0] lvl_a, prs_a, rel_a;
   logic [NK-1:0] lvl_b, prs_b, rel_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   key_debounce #(.N_KEYS(NK), .CNT_MAX(CM), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut_a (
      .clk(clk), .rst(rst), .key_in(key_in),
      .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a));

   key_debounce #(.N_KEYS(NK), .CNT_MAX(CM), .REPEAT_DELAY(0), .REPEAT_PERIOD(RP)) u_dut_b (
      .clk(clk), .rst(rst), .key_in(key_in),
      .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b));

   // Reference: a level change is accepted on the CM-th consecutive synchronised
   // sample that disagrees with the accepted level; repeats count stable held samples.
   logic [NK-1:0] m_lvl, m_prs_a, m_prs_b, m_rel;
   logic [NK-1:0] m_d1, m_d2;
   int            m_run [NK];
   int            m_held[NK];

   initial begin
      m_lvl = '0; m_prs_a = '0; m_prs_b = '0; m_rel = '0; m_d1 = '0; m_d2 = '0;
      for (int k = 0; k < NK; k++) begin m_run[k] = 0; m_held[k] = 0; end
   end

   always @(posedge clk) begin
      for (int k = 0; k < NK; k++) begin
         m_prs_a[k] = 1'b0; m_prs_b[k] = 1'b0; m_rel[k] = 1'b0;
         if (!rst) begin
            m_lvl[k] = 1'b0; m_d1[k] = 1'b0; m_d2[k] = 1'b0;
            m_run[k] = 0; m_held[k] = 0;
         end else begin
            if (m_d2[k] != m_lvl[k]) begin
               m_run[k]++;
               if (m_run[k] == CM) begin
                  m_lvl[k] = m_d2[k];
                  m_run[k] = 0;
                  if (m_lvl[k]) begin
                     m_prs_a[k] = 1'b1; m_prs_b[k] = 1'b1; m_held[k] = 0;
                  end else begin
                     m_rel[k] = 1'b1;
                  end
               end
            end else begin
               if (m_lvl[k] && m_run[k] == 0) begin
                  m_held[k]++;
                  if (m_held[k] == RD || (m_held[k] > RD && (m_held[k] - RD) % RP == 0))
                     m_prs_a[k] = 1'b1;
               end
               m_run[k] = 0;
            end
            m_d2[k] = m_d1[k];
            m_d1[k] = key_in[k];
         end
      end
   end

   // Per-phase statistics gathered at sampling time
   int            ph_cyc;
   int            first_prs_cyc;
   int            first_rel_cyc;
   logic [NK-1:0] first_prs_vec;
   logic [NK-1:0] first_rel_vec;
   int            cnt_prs_a[NK];
   int            cnt_prs_b[NK];
   int            cnt_rel_a[NK];
   logic [NK-1:0] ever_lvl;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_stats();
      ph_cyc = 0; first_prs_cyc = -1; first_rel_cyc = -1;
      first_prs_vec = '0; first_rel_vec = '0; ever_lvl = '0;
      for (int k = 0; k < NK; k++) begin
         cnt_prs_a[k] = 0; cnt_prs_b[k] = 0; cnt_rel_a[k] = 0;
      end
   endtask

   task automatic run_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ph_cyc++;
         check_eq("level_a",   32'(lvl_a), 32'(m_lvl));
         check_eq("press_a",   32'(prs_a), 32'(m_prs_a));
         check_eq("release_a", 32'(rel_a), 32'(m_rel));
         check_eq("level_b",   32'(lvl_b), 32'(m_lvl));
         check_eq("press_b",   32'(prs_b), 32'(m_prs_b));
         check_eq("release_b", 32'(rel_b), 32'(m_rel));
         if (prs_a != '0 && first_prs_cyc < 0) begin first_prs_cyc = ph_cyc; first_prs_vec = prs_a; end
         if (rel_a != '0 && first_rel_cyc < 0) begin first_rel_cyc = ph_cyc; first_rel_vec = rel_a; end
         ever_lvl |= lvl_a;
         for (int k = 0; k < NK; k++) begin
            cnt_prs_a[k] += int'(prs_a[k]);
            cnt_prs_b[k] += int'(prs_b[k]);
            cnt_rel_a[k] += int'(rel_a[k]);
         end
      end
   endtask

   int rem[NK];

   initial begin
      // 1. reset with all buttons pressed, then release reset
      clear_stats();
      run_cycles(3);
      check_eq("rst_outputs_zero", 32'({lvl_a, prs_a, rel_a}), 32'h0);
      rst = 1'b1;
      clear_stats();
      run_cycles(12);
      check_eq("rst_first_press_cyc", 32'(first_prs_cyc), 32'd10);
      check_eq("rst_first_press_vec", 32'(first_prs_vec), 32'hF);
      check_eq("rst_press_once_k3",   32'(cnt_prs_a[3]), 32'd1);
      check_eq("rst_level_all",       32'(lvl_a), 32'hF);
      key_in = '0;
      run_cycles(14);

      // 2. bounce on key 0
      clear_stats();
      for (int i = 0; i < 40; i++) begin
         key_in[0] = ((i / 3) % 2) == 0;
         run_cycles(1);
      end
      key_in[0] = 1'b0;
      run_cycles(15);
      check_eq("bounce_press_cnt", 32'(cnt_prs_a[0]), 32'd0);
      check_eq("bounce_level",     32'(ever_lvl[0]), 32'd0);

      // 3. clean press/release on key 1, held 30 cycles
      clear_stats();
      key_in[1] = 1'b1;
      run_cycles(30);
      key_in[1] = 1'b0;
      run_cycles(20);
      check_eq("clean_press_cyc",    32'(first_prs_cyc), 32'd10);
      check_eq("clean_release_cyc",  32'(first_rel_cyc), 32'd40);
      check_eq("clean_press_b_cnt",  32'(cnt_prs_b[1]), 32'd1);
      check_eq("clean_press_a_cnt",  32'(cnt_prs_a[1]), 32'd2);
      check_eq("clean_release_cnt",  32'(cnt_rel_a[1]), 32'd1);

      // 4. auto-repeat on key 2, held 50 cycles
      clear_stats();
      key_in[2] = 1'b1;
      run_cycles(50);
      key_in[2] = 1'b0;
      run_cycles(40);
      check_eq("rpt_press_a_cnt", 32'(cnt_prs_a[2]), 32'd6);
      check_eq("rpt_press_b_cnt", 32'(cnt_prs_b[2]), 32'd1);

      // 5. simultaneous keys 3 and 0
      clear_stats();
      key_in = 4'b1001;
      run_cycles(15);
      check_eq("simul_press_vec", 32'(first_prs_vec), 32'h9);
      key_in = 4'b0001;
      run_cycles(15);
      check_eq("simul_release_vec", 32'(first_rel_vec), 32'h8);
      check_eq("simul_level",       32'(lvl_a), 32'h1);
      key_in = '0;
      run_cycles(15);

      // 6. reset during DEB_PRESS (cnt=5) and again in HELD
      clear_stats();
      key_in[1] = 1'b1;
      run_cycles(7);
      rst = 1'b0;
      run_cycles(1);
      check_eq("mid_rst_level", 32'(lvl_a), 32'h0);
      rst = 1'b1;
      clear_stats();
      run_cycles(12);
      check_eq("mid_rst_redeb_cyc", 32'(first_prs_cyc), 32'd10);
      rst = 1'b0;
      run_cycles(2);
      check_eq("held_rst_outputs", 32'({lvl_a, prs_a, rel_a}), 32'h0);
      rst = 1'b1;
      clear_stats();
      run_cycles(2);
      check_eq("held_rst_no_pulse", 32'(cnt_prs_a[1] + cnt_rel_a[1]), 32'd0);
      key_in[1] = 1'b0;
      run_cycles(15);
      clear_stats();
      key_in[1] = 1'b1;
      run_cycles(12);
      check_eq("post_rst_press_cyc", 32'(first_prs_cyc), 32'd10);
      key_in[1] = 1'b0;
      run_cycles(15);

      // Random phase: mix of glitches and long holds, occasional resets
      for (int k = 0; k < NK; k++) rem[k] = 0;
      for (int i = 0; i < 2000; i++) begin
         for (int k = 0; k < NK; k++) begin
            if (rem[k] == 0) begin
               key_in[k] = 1'($urandom_range(0, 1));
               rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7))
                                                   : int'($urandom_range(8, 60));
            end
            rem[k]--;
         end
         rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
         run_cycles(1);
      end
      rst = 1'b1;
      run_cycles(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
